// File: rtl/heho_checker_if.sv
// ---------------------------------------------------------------------------
// heho_checker_if
//   Groups the sample stream and the checker status outputs into one bundle.
//
//   Sample side (driven by the upstream source / testbench):
//     in_valid  1  in_cnt carries a sample this cycle
//     in_cnt    8  sample from the half-even/half-odd counter
//   Status side (driven by heho_checker):
//     locked    1  checker is in LOCKED
//     phase     1  half of the last accepted legal sample (0 even, 1 odd)
//     err       1  one-cycle pulse on a sequence break while LOCKED
//     err_cnt   8  saturating count of err pulses (0 when the counter is not built)
//     wrap_cnt  8  count of 99->0 transitions seen while LOCKED, wraps modulo 256
//
//   Modports: master = sample source, slave = checker.
// ---------------------------------------------------------------------------
interface heho_checker_if;
  logic       in_valid;
  logic [7:0] in_cnt;
  logic       locked;
  logic       phase;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  modport master (
    output in_valid,
    output in_cnt,
    input  locked,
    input  phase,
    input  err,
    input  err_cnt,
    input  wrap_cnt
  );

  modport slave (
    input  in_valid,
    input  in_cnt,
    output locked,
    output phase,
    output err,
    output err_cnt,
    output wrap_cnt
  );
endinterface

// File: rtl/heho_checker.sv
// ---------------------------------------------------------------------------
// heho_checker
//   Sequence checker for a half-even/half-odd counter. The legal counter
//   pattern is 0,2,...,50,51,53,...,99,0,... The checker locks after
//   LOCK_LEN consecutive correctly sequenced samples and, once locked,
//   flags every sequence break with a one-cycle err pulse.
//
//   Parameters:
//     LOCK_LEN  consecutive good samples needed to lock (2..15, default 3)
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   heho_checker_if.slave: in_valid/in_cnt in, locked/phase/err/
//           err_cnt/wrap_cnt out (all outputs registered, one cycle after
//           the sample's in_valid cycle)
//
//   Build option:
//     HEHO_CHECKER_ERRCNT_EN  when defined, the saturating error counter is
//                             built; otherwise err_cnt is tied to 0.
// ---------------------------------------------------------------------------
module heho_checker #(
  parameter int unsigned LOCK_LEN = 3
) (
  input  logic          clk,
  input  logic          rst,
  heho_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);

  // -------------------------------------------------------------------------
  // Sample classification helpers
  // -------------------------------------------------------------------------
  // Legal: even 0..50 or odd 51..99.
  function automatic logic is_legal(input logic [7:0] x);
    logic res;
    res = 1'b0;
    if (x <= 8'd50) begin
      res = ~x[0];
    end else if (x <= 8'd99) begin
      res = x[0];
    end
    return res;
  endfunction

  // Successor of a legal value: 99 wraps to 0, 50 steps into the odd half.
  function automatic logic [7:0] succ_of(input logic [7:0] x);
    logic [7:0] res;
    if (x == 8'd99) begin
      res = 8'd0;
    end else if (x == 8'd50) begin
      res = 8'd51;
    end else begin
      res = x + 8'd2;
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t     state_reg,    state_next;
  logic [3:0] match_reg,    match_next;
  logic [7:0] prev_reg,     prev_next;
  logic       locked_reg;
  logic       phase_reg,    phase_next;
  logic       err_reg,      err_next;
  logic [7:0] wrap_cnt_reg;
  logic       wrap_inc;

  // Sample classification shared by both combinational processes.
  logic       sample_legal;
  logic       sample_is_succ;
  logic [3:0] match_inc;

  assign sample_legal   = is_legal(bus.in_cnt);
  // prev_reg only holds a legal value whenever the FSM is out of UNLOCKED,
  // so comparing against its successor is meaningful there.
  assign sample_is_succ = (bus.in_cnt == succ_of(prev_reg));
  assign match_inc      = match_reg + 4'd1;

  // -------------------------------------------------------------------------
  // Process 1: state register (plus the registered outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_UNLOCKED;
      match_reg    <= 4'd0;
      prev_reg     <= 8'd0;
      locked_reg   <= 1'b0;
      phase_reg    <= 1'b0;
      err_reg      <= 1'b0;
      wrap_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      match_reg    <= match_next;
      prev_reg     <= prev_next;
      // locked follows the state the FSM is entering, so it is high exactly
      // while state_reg is LOCKED without a decode after the register.
      locked_reg   <= (state_next == ST_LOCKED);
      phase_reg    <= phase_next;
      err_reg      <= err_next;
      if (wrap_inc) begin
        wrap_cnt_reg <= wrap_cnt_reg + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    match_next = match_reg;
    prev_next  = prev_reg;

    if (bus.in_valid) begin
      case (state_reg)
        ST_UNLOCKED: begin
          if (sample_legal) begin
            prev_next  = bus.in_cnt;
            match_next = 4'd1;
            state_next = ST_LOCKING;
          end
        end

        ST_LOCKING: begin
          if (sample_is_succ) begin
            prev_next  = bus.in_cnt;
            match_next = match_inc;
            if (match_inc >= LOCK_LEN_C) begin
              state_next = ST_LOCKED;
            end
          end else if (sample_legal) begin
            // A legal but out-of-order value restarts the run from itself.
            prev_next  = bus.in_cnt;
            match_next = 4'd1;
          end else begin
            match_next = 4'd0;
            state_next = ST_UNLOCKED;
          end
        end

        ST_LOCKED: begin
          if (sample_is_succ) begin
            prev_next = bus.in_cnt;
          end else if (sample_legal) begin
            prev_next  = bus.in_cnt;
            match_next = 4'd1;
            state_next = ST_LOCKING;
          end else begin
            match_next = 4'd0;
            state_next = ST_UNLOCKED;
          end
        end

        default: begin
          match_next = 4'd0;
          state_next = ST_UNLOCKED;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Process 3: output logic (next values of the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    phase_next = phase_reg;
    err_next   = 1'b0;
    wrap_inc   = 1'b0;

    if (bus.in_valid) begin
      // phase tracks every accepted legal sample regardless of state.
      if (sample_legal) begin
        phase_next = (bus.in_cnt >= 8'd51);
      end

      if (state_reg == ST_LOCKED) begin
        // An illegal value can never equal a successor, so a single
        // inequality covers both break kinds.
        err_next = ~sample_is_succ;
        wrap_inc = sample_is_succ && (prev_reg == 8'd99) && (bus.in_cnt == 8'd0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Error counter (optional)
  // -------------------------------------------------------------------------
`ifdef HEHO_CHECKER_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= 8'd0;
    end else if (err_next && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`else
  assign bus.err_cnt = 8'd0;
`endif

  // -------------------------------------------------------------------------
  // Port drive
  // -------------------------------------------------------------------------
  assign bus.locked   = locked_reg;
  assign bus.phase    = phase_reg;
  assign bus.err      = err_reg;
  assign bus.wrap_cnt = wrap_cnt_reg;

endmodule

// File: tb/tb_heho_checker.sv
// ---------------------------------------------------------------------------
// tb_heho_checker
//   Self-checking bench for heho_checker (LOCK_LEN = 3). A reference model
//   tracks the length of the current run of correctly sequenced samples;
//   the checker is locked whenever that run is at least LOCK_LEN long.
//   Directed sequences exercise the documented scenarios, then a random
//   phase mixes correct successors, breaks, illegal values, gaps and resets.
// ---------------------------------------------------------------------------
module tb_heho_checker;
  localparam int L = 3;

  logic clk;
  logic rst;
  heho_checker_if bus ();

  heho_checker #(.LOCK_LEN(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int run_len  = 0;
  int m_prev   = 0;
  bit m_phase  = 0;
  bit m_err    = 0;
  int m_errcnt = 0;
  int m_wrap   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit legal(input int x);
    return ((x <= 50) && (x % 2 == 0)) || ((x >= 51) && (x <= 99) && (x % 2 == 1));
  endfunction

  function automatic int succ(input int x);
    if (x == 99) return 0;
    if (x == 50) return 51;
    return x + 2;
  endfunction

  function automatic bit m_locked();
    return run_len >= L;
  endfunction

  // Advance the model by one clock with the given inputs.
  task automatic model_step(input bit v, input int c, input bit r);
    bit was_locked;
    bit chain;
    if (r) begin
      run_len = 0; m_prev = 0; m_phase = 0; m_err = 0; m_errcnt = 0; m_wrap = 0;
    end else if (v) begin
      was_locked = m_locked();
      chain = (run_len > 0) && (c == succ(m_prev));
      if (chain) begin
        if (was_locked && m_prev == 99 && c == 0) m_wrap = (m_wrap + 1) % 256;
        run_len = (run_len + 1 > L) ? L : run_len + 1;
      end else if (legal(c)) begin
        run_len = 1;
      end else begin
        run_len = 0;
      end
      m_err = was_locked && !chain;
`ifdef HEHO_CHECKER_ERRCNT_EN
      if (m_err && m_errcnt < 255) m_errcnt++;
`endif
      if (legal(c)) begin
        m_prev  = c;
        m_phase = (c >= 51);
      end
    end else begin
      m_err = 0;
    end
  endtask

  // Drive one cycle, then compare every output with the model.
  task automatic step(input bit v, input int c, input bit r);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.in_cnt   = 8'(c);
    @(posedge clk);
    #1;
    model_step(v, c, r);
    $display("txn v=%0d cnt=%0d rst=%0d -> locked=%0d phase=%0d err=%0d err_cnt=%0d wrap_cnt=%0d",
             v, c, r, bus.locked, bus.phase, bus.err, bus.err_cnt, bus.wrap_cnt);
    check("locked",   32'(bus.locked),   32'(m_locked()));
    check("phase",    32'(bus.phase),    32'(m_phase));
    check("err",      32'(bus.err),      32'(m_err));
    check("err_cnt",  32'(bus.err_cnt),  32'(m_errcnt));
    check("wrap_cnt", 32'(bus.wrap_cnt), 32'(m_wrap));
  endtask

  task automatic feed(input int c);
    step(1'b1, c, 1'b0);
  endtask

  initial begin
    int gen_prev;
    int r;
    int c;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_cnt   = 8'd0;

    // Reset state
    step(1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b1);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_wrap",   32'(bus.wrap_cnt), 32'd0);

    // Lock on 0,2,4
    feed(0);
    feed(2);
    check("lock_early", 32'(bus.locked), 32'd0);
    feed(4);
    check("lock_after_4", 32'(bus.locked), 32'd1);

    // Walk up to 46, then across the even/odd boundary
    for (int x = 6; x <= 46; x += 2) feed(x);
    feed(48); check("phase_48", 32'(bus.phase), 32'd0);
    feed(50); check("phase_50", 32'(bus.phase), 32'd0);
    feed(51); check("phase_51", 32'(bus.phase), 32'd1);
    feed(53); check("phase_53", 32'(bus.phase), 32'd1);
    check("no_err_boundary", 32'(bus.err), 32'd0);

    // Wrap 99 -> 0
    for (int x = 55; x <= 99; x += 2) feed(x);
    check("wrap_before", 32'(bus.wrap_cnt), 32'd0);
    feed(0);
    check("wrap_after_0", 32'(bus.wrap_cnt), 32'd1);
    feed(2);
    check("wrap_locked", 32'(bus.locked), 32'd1);

    // Sequence break and relock
    for (int x = 4; x <= 10; x += 2) feed(x);
    feed(14);
    check("break_err",    32'(bus.err),    32'd1);
    check("break_locked", 32'(bus.locked), 32'd0);
    feed(16);
    check("err_one_cycle", 32'(bus.err), 32'd0);
    feed(18);
    check("relock", 32'(bus.locked), 32'd1);

    // Illegal value while locked
    feed(7);
    check("illegal_err", 32'(bus.err), 32'd1);
    feed(0);
    check("illegal_unlocked", 32'(bus.locked), 32'd0);

    // Relock, then in_valid gaps between 20 and 22
    feed(20 - 4); feed(20 - 2); feed(20);
    step(1'b0, 99, 1'b0);
    step(1'b0, 7, 1'b0);
    feed(22);
    check("gap_no_err", 32'(bus.err), 32'd0);
    check("gap_locked", 32'(bus.locked), 32'd1);

    // Mid-sequence reset with a valid sample present
    step(1'b1, 24, 1'b1);
    check("midrst_locked", 32'(bus.locked), 32'd0);
    check("midrst_phase",  32'(bus.phase),  32'd0);
    check("midrst_wrap",   32'(bus.wrap_cnt), 32'd0);

    // Randomized traffic
    gen_prev = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 100) begin
        step(1'b0, int'($urandom_range(0, 255)), 1'b0);
      end else if (r < 130) begin
        c = int'($urandom_range(0, 49)) * 2;
        if (c > 50) c = c + 1;
        gen_prev = c;
        feed(c);
      end else if (r < 150) begin
        c = int'($urandom_range(0, 255));
        if (legal(c)) gen_prev = c;
        feed(c);
      end else if (r < 155) begin
        step(1'b1, gen_prev, 1'b1);
      end else begin
        gen_prev = succ(gen_prev);
        feed(gen_prev);
      end
    end

    // Drive the error counter into saturation
    for (int k = 0; k < 260; k++) begin
      feed(0); feed(2); feed(4); feed(7);
    end
`ifdef HEHO_CHECKER_ERRCNT_EN
    check("errcnt_sat", 32'(bus.err_cnt), 32'd255);
`else
    check("errcnt_off", 32'(bus.err_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
